// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequential fetch PC feeding a 2-entry prefetch FIFO,
// with redirect flush and halt.
module ifetch_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  output logic [7:0]  IMEM_ADDR,
  input  logic [15:0] IMEM_Q,
  output logic [15:0] INSTR,
  output logic [7:0]  INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  input  logic        REDIRECT,
  input  logic [7:0]  REDIRECT_PC,
  input  logic        HALT,
  output logic [1:0]  FIFO_COUNT
);

  logic [7:0]  fetch_pc;
  logic [7:0]  pc_mem [2];
  logic [15:0] instr_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        pop;
  logic        push;

  assign pop  = (count != 2'd0) && INSTR_READY;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign push = !REDIRECT && !HALT && ((count != 2'd2) || pop);

  assign IMEM_ADDR   = fetch_pc;
  assign INSTR       = instr_mem[rd_ptr];
  assign INSTR_PC    = pc_mem[rd_ptr];
  assign INSTR_VALID = (count != 2'd0);
  assign FIFO_COUNT  = count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= 8'h00;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & 8'hFE;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 8'd2;
        wr_ptr   <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= IMEM_Q;
    end
  end

endmodule
